pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. It drives the stall (`hazard_i`) and flush (`flush_i`) controls of the IF/ID register, the PC write enable, ID/EX bubble insertion and a whole-pipe freeze for multi-cycle data memory. It also sequences start-up after reset. It resolves load-use, taken-branch and memory-wait conditions with a fixed priority and a small state machine.

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencer: start-up flush, load-use, branch flush, memory freeze
// Outputs decode the current state and inputs; only the sequencing state is registered.
module pipe_hazard_ctrl #(
  parameter int STARTUP_CYC = 2,
  parameter int FLUSH_CYC   = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       start_i,
  input  logic [4:0] idRs1_i,
  input  logic [4:0] idRs2_i,
  input  logic [4:0] exRd_i,
  input  logic       exMemRead_i,
  input  logic       branchTaken_i,
  input  logic       memReq_i,
  input  logic       memReady_i,
  output logic       pcWrite_o,
  output logic       ifidHazard_o,
  output logic       ifidFlush_o,
  output logic       idexBubble_o,
  output logic       pipeStall_o,
  output logic       ready_o,
  output logic       memErr_o,
  output logic [2:0] state_o
);

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_RUN      = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] STARTUP_INIT = 8'(STARTUP_CYC);
  localparam logic [7:0] FLUSH_INIT   = 8'(FLUSH_CYC - 1);
  localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

  state_t     state, ret_state;
  logic [7:0] cnt, flush_rem;
  logic       mem_err;
  logic       mem_wait, load_use;
  logic       pc_write, ifid_hazard, ifid_flush, idex_bubble, pipe_stall;

  assign mem_wait = memReq_i & ~memReady_i;
  assign load_use = exMemRead_i & (exRd_i != 5'd0) &
                    ((exRd_i == idRs1_i) | (exRd_i == idRs2_i));

  always_comb begin
    pc_write    = 1'b0;
    ifid_hazard = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_stall  = 1'b0;
    case (state)
      ST_STARTUP: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      ST_RUN: begin
        if (mem_wait) begin
          pipe_stall  = 1'b1;
          ifid_hazard = 1'b1;
        end else if (branchTaken_i) begin
          pc_write    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          ifid_hazard = 1'b1;
          idex_bubble = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
      end
      ST_FLUSH: begin
        // A memory wait freezes the pipe without consuming a flush cycle.
        if (mem_wait) begin
          pipe_stall  = 1'b1;
          ifid_hazard = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!memReady_i && cnt != TIMEOUT) begin
          pipe_stall  = 1'b1;
          ifid_hazard = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state     <= ST_STARTUP;
      ret_state <= ST_RUN;
      cnt       <= STARTUP_INIT;
      flush_rem <= 8'd0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        ST_STARTUP: begin
          if (cnt <= 8'd1) state <= ST_RUN;
          else             cnt   <= cnt - 8'd1;
        end
        ST_RUN: begin
          if (mem_wait) begin
            state     <= ST_MEM_WAIT;
            ret_state <= ST_RUN;
            cnt       <= 8'd1;
          end else if (branchTaken_i && FLUSH_CYC > 1) begin
            state <= ST_FLUSH;
            cnt   <= FLUSH_INIT;
          end
        end
        ST_FLUSH: begin
          if (mem_wait) begin
            state     <= ST_MEM_WAIT;
            ret_state <= ST_FLUSH;
            flush_rem <= cnt;
            cnt       <= 8'd1;
          end else if (branchTaken_i) begin
            cnt <= FLUSH_INIT;
          end else if (cnt <= 8'd1) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (memReady_i || cnt == TIMEOUT) begin
            state <= ret_state;
            cnt   <= flush_rem;
            if (!memReady_i) mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign pcWrite_o    = pc_write;
  assign ifidFlush_o  = ifid_flush;
  assign ifidHazard_o = ifid_hazard & ~ifid_flush;
  assign idexBubble_o = idex_bubble;
  assign pipeStall_o  = pipe_stall;
  assign ready_o      = (state != ST_STARTUP);
  assign memErr_o     = mem_err;
  assign state_o      = {1'b0, state};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl
// Control vector order: {pcWrite, ifidHazard, ifidFlush, idexBubble, pipeStall, ready, memErr}.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       start_i;
  logic [4:0] idRs1_i, idRs2_i, exRd_i;
  logic       exMemRead_i, branchTaken_i, memReq_i, memReady_i;
  logic       pcWrite_o, ifidHazard_o, ifidFlush_o, idexBubble_o, pipeStall_o;
  logic       ready_o, memErr_o;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] C_RESET = 7'b0011000;
  localparam logic [6:0] C_RUN   = 7'b1000010;
  localparam logic [6:0] C_LU    = 7'b0101010;
  localparam logic [6:0] C_FLUSH = 7'b1011010;
  localparam logic [6:0] C_STALL = 7'b0100110;
  localparam logic [6:0] C_ERR   = 7'b1000011;

  pipe_hazard_ctrl #(.STARTUP_CYC(2), .FLUSH_CYC(2), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .idRs1_i(idRs1_i), .idRs2_i(idRs2_i), .exRd_i(exRd_i),
    .exMemRead_i(exMemRead_i), .branchTaken_i(branchTaken_i),
    .memReq_i(memReq_i), .memReady_i(memReady_i),
    .pcWrite_o(pcWrite_o), .ifidHazard_o(ifidHazard_o), .ifidFlush_o(ifidFlush_o),
    .idexBubble_o(idexBubble_o), .pipeStall_o(pipeStall_o),
    .ready_o(ready_o), .memErr_o(memErr_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [6:0] exp_ctl, input logic [2:0] exp_st);
    logic [9:0] obs, exp;
    #1;
    obs = {pcWrite_o, ifidHazard_o, ifidFlush_o, idexBubble_o, pipeStall_o,
           ready_o, memErr_o, state_o};
    exp = {exp_ctl, exp_st};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic br, input logic mreq, input logic mrdy, input logic lu);
    branchTaken_i = br;
    memReq_i      = mreq;
    memReady_i    = mrdy;
    exMemRead_i   = lu;
    exRd_i        = lu ? 5'd5 : 5'd0;
    idRs1_i       = 5'd3;
    idRs2_i       = lu ? 5'd5 : 5'd0;
  endtask

  initial begin
    start_i = 1'b0;
    drive(0, 0, 0, 0);
    #3 chk("reset", C_RESET, 3'd0);

    next_cycle; start_i = 1'b1;
    chk("startup_c1", C_RESET, 3'd0);
    next_cycle; chk("startup_c2", C_RESET, 3'd0);
    next_cycle; chk("run_entry", C_RUN, 3'd1);

    // load-use on rs2, then cleared, then rd=0, rs1 match, non-load match
    next_cycle; drive(0, 0, 0, 1); chk("lu_rs2", C_LU, 3'd1);
    next_cycle; drive(0, 0, 0, 0); chk("lu_cleared", C_RUN, 3'd1);
    next_cycle; exMemRead_i = 1; exRd_i = 0; idRs1_i = 0; idRs2_i = 0;
    chk("lu_rd_zero", C_RUN, 3'd1);
    next_cycle; exMemRead_i = 1; exRd_i = 7; idRs1_i = 7; idRs2_i = 1;
    chk("lu_rs1", C_LU, 3'd1);
    next_cycle; exMemRead_i = 0; chk("lu_not_load", C_RUN, 3'd1);

    // single branch: FLUSH_CYC=2 cycles of flush
    next_cycle; drive(1, 0, 0, 0); chk("br_cycle", C_FLUSH, 3'd1);
    next_cycle; drive(0, 0, 0, 0); chk("br_flush", C_FLUSH, 3'd2);
    next_cycle; chk("br_done", C_RUN, 3'd1);

    // second branch during FLUSH reloads, load-use ignored in FLUSH
    next_cycle; drive(1, 0, 0, 0); chk("br2_cycle", C_FLUSH, 3'd1);
    next_cycle; chk("br2_reload", C_FLUSH, 3'd2);
    next_cycle; drive(0, 0, 0, 1); chk("br2_extra", C_FLUSH, 3'd2);
    next_cycle; drive(0, 0, 0, 0); chk("br2_done", C_RUN, 3'd1);

    // memory wait of 3 cycles
    next_cycle; drive(0, 1, 0, 0); chk("mw_c1", C_STALL, 3'd1);
    next_cycle; chk("mw_c2", C_STALL, 3'd3);
    next_cycle; chk("mw_c3", C_STALL, 3'd3);
    next_cycle; memReady_i = 1; chk("mw_ready", C_RUN, 3'd3);
    next_cycle; drive(0, 0, 0, 0); chk("mw_back", C_RUN, 3'd1);

    // memory wait entered from FLUSH resumes the remaining flush cycle
    next_cycle; drive(1, 0, 0, 0); chk("fmw_br", C_FLUSH, 3'd1);
    next_cycle; drive(0, 1, 0, 0); chk("fmw_stall", C_STALL, 3'd2);
    next_cycle; chk("fmw_wait", C_STALL, 3'd3);
    next_cycle; memReady_i = 1; chk("fmw_ready", C_RUN, 3'd3);
    next_cycle; drive(0, 0, 0, 0); chk("fmw_resume", C_FLUSH, 3'd2);
    next_cycle; chk("fmw_done", C_RUN, 3'd1);

    // timeout: 15 stall cycles, then abort cycle, then sticky memErr
    next_cycle; drive(0, 1, 0, 0); chk("to_stall0", C_STALL, 3'd1);
    for (int i = 1; i < 15; i++) begin
      next_cycle; chk($sformatf("to_stall%0d", i), C_STALL, 3'd3);
    end
    next_cycle; chk("to_abort", C_RUN, 3'd3);
    next_cycle; drive(0, 0, 0, 0); chk("to_err_run", C_ERR, 3'd1);
    next_cycle; drive(0, 0, 0, 1); chk("to_err_sticky_lu", C_LU | 7'b0000001, 3'd1);
    next_cycle; drive(0, 0, 0, 0); chk("to_err_sticky", C_ERR, 3'd1);

    // asynchronous reset mid-operation
    #1 start_i = 1'b0;
    chk("midreset", C_RESET, 3'd0);
    next_cycle; start_i = 1'b1; chk("rerelease", C_RESET, 3'd0);
    next_cycle; chk("restartup", C_RESET, 3'd0);
    next_cycle; chk("rerun_no_err", C_RUN, 3'd1);

    // mem wait + branch together, load-use during MEM_WAIT, branch re-presented
    next_cycle; drive(1, 1, 0, 0); chk("mix_stall", C_STALL, 3'd1);
    next_cycle; drive(1, 1, 0, 1); chk("mix_wait", C_STALL, 3'd3);
    next_cycle; memReady_i = 1; chk("mix_ready", C_RUN, 3'd3);
    next_cycle; drive(1, 0, 0, 0); chk("mix_br", C_FLUSH, 3'd1);
    next_cycle; drive(0, 0, 0, 0); chk("mix_flush", C_FLUSH, 3'd2);
    next_cycle; chk("mix_done", C_RUN, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
